// File: rtl/mfp_vector_decoder.sv
// mfp_vector_decoder: two-stage decoder of encoded vector commands into the pending vector read by the priority encoders
module mfp_vector_decoder #(
    parameter int W = 8,
    parameter int CNT_W = 8,
    localparam int N = 2**W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [W-1:0]     cmd_idx,
    input  logic             hold,
    input  logic             ack_valid,
    input  logic [W-1:0]     ack_idx,
    output logic [N-1:0]     pending,
    output logic             any_pending,
    output logic [N-1:0]     strobe,
    output logic [CNT_W-1:0] ovf_cnt
);
    localparam logic [1:0] op_set = 2'b01;
    localparam logic [1:0] op_clr = 2'b10;
    localparam logic [1:0] op_clr_all = 2'b11;

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [N-1:0]     s1_onehot;
    logic             apply;
    logic [N-1:0]     ack_m, set_m, clr_m;

    function automatic logic [N-1:0] onehot(input logic [W-1:0] i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction

    assign cmd_ready = ~s1_valid | ~hold;
    assign any_pending = |pending;

    // masks for the edge: stage-2 command (set/clear) and the consumer acknowledge
    always_comb begin
        apply = s1_valid & ~hold;
        ack_m = ack_valid ? onehot(ack_idx) : '0;
        set_m = (apply && s1_op == op_set) ? s1_onehot : '0;
        clr_m = (apply && s1_op == op_clr_all) ? '1 : (apply && s1_op == op_clr) ? s1_onehot : '0;
    end

    // stage 1: capture and decode an accepted command, drop it once applied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op <= 2'b00;
            s1_onehot <= '0;
        end else if (cmd_valid && cmd_ready) begin
            s1_valid <= 1'b1;
            s1_op <= cmd_op;
            s1_onehot <= onehot(cmd_idx);
        end else if (apply) begin
            s1_valid <= 1'b0;
        end
    end

    // stage 2: clears (command and ack) first, then set, so a set beats a same-edge ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            strobe <= '0;
            ovf_cnt <= '0;
        end else begin
            pending <= (pending & ~clr_m & ~ack_m) | set_m;
            strobe <= set_m & ~pending;
            if (|(set_m & pending) && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule
